// File: rtl/vga_output_conditioner_if.sv
// Bundle between a VGA pixel source and the output conditioner.
//   master: the timing generator / colour source. It drives sync, display_on,
//           the pixel-coordinate LSBs and colour, and it observes the pin-side
//           outputs and the timing-check flags.
//   slave : the conditioner. It takes the source signals and drives the pins
//           and the flags.
// Source-side signals:
//   hsync, vsync   1 = inside the sync pulse
//   display_on     1 = active pixel
//   x0, y0         LSBs of the pixel coordinates (used for dither)
//   red_in, green_in, blue_in   pixel colour
// Pin-side signals:
//   vga_hsync, vga_vsync        sync pins
//   vga_red, vga_green, vga_blue colour pins
//   sticky_failure, failure_cause  timing-check flags
interface vga_output_conditioner_if #(
  parameter int w_red_in    = 8,
  parameter int w_green_in  = 8,
  parameter int w_blue_in   = 8,
  parameter int w_red_out   = 2,
  parameter int w_green_out = 2,
  parameter int w_blue_out  = 2
);
  logic                   hsync;
  logic                   vsync;
  logic                   display_on;
  logic                   x0;
  logic                   y0;
  logic [w_red_in-1:0]    red_in;
  logic [w_green_in-1:0]  green_in;
  logic [w_blue_in-1:0]   blue_in;

  logic                   vga_hsync;
  logic                   vga_vsync;
  logic [w_red_out-1:0]   vga_red;
  logic [w_green_out-1:0] vga_green;
  logic [w_blue_out-1:0]  vga_blue;
  logic                   sticky_failure;
  logic [2:0]             failure_cause;

  modport master (
    output hsync, vsync, display_on, x0, y0, red_in, green_in, blue_in,
    input  vga_hsync, vga_vsync, vga_red, vga_green, vga_blue,
           sticky_failure, failure_cause
  );

  modport slave (
    input  hsync, vsync, display_on, x0, y0, red_in, green_in, blue_in,
    output vga_hsync, vga_vsync, vga_red, vga_green, vga_blue,
           sticky_failure, failure_cause
  );
endinterface

// File: rtl/vga_output_conditioner.sv
// Registered VGA output stage.
//
// This block sits between the timing generator / colour source and the board
// pins. It does four things:
//   - delays sync and colour together through pipe_stages registers (1..4),
//     so the two can never be skewed against each other;
//   - forces colour to zero outside the active area;
//   - converts each colour channel to the pin width, with optional 2x2
//     ordered dither;
//   - checks the incoming timing and latches any violation into sticky flags.
//
// Ports:
//   clk  clock
//   rst  synchronous reset, active-high
//   bus  vga_output_conditioner_if.slave: source-side inputs, pin-side outputs
//        and the failure flags
//
// Timing checker states (one copy for hsync, one for vsync):
//   state   | meaning
//   unarmed | no rising edge seen since reset; the next edge only arms
//   armed   | every later rising edge compares the period counter

// One colour channel: width conversion, with optional ordered dither.
module vga_chan_conv #(
  parameter int w_in      = 8,
  parameter int w_out     = 2,
  parameter int dither_en = 1
) (
  input  logic [w_in-1:0]  din,
  input  logic             x0,
  input  logic             y0,
  output logic [w_out-1:0] dout
);
  localparam int d  = w_in - w_out;
  localparam int ws = w_in + 1;

  if (d <= 0) begin : g_expand
    // Left-justify the input, then fill the low bits by repeating its MSBs.
    logic unused_xy;
    assign unused_xy = x0 ^ y0;
    always_comb begin
      dout = '0;
      for (int i = 0; i < w_out; i++) begin
        dout[w_out-1-i] = din[w_in-1-(i % w_in)];
      end
    end
  end else if (dither_en == 0) begin : g_trunc
    logic unused_xy;
    assign unused_xy = ^{x0, y0, din[d-1:0]};
    assign dout = din[w_in-1:d];
  end else begin : g_dither
    logic [1:0]   t;
    logic [ws-1:0] ts;
    logic [ws-1:0] sum;
    logic [w_out:0] q;
    logic unused_low;

    // 2x2 Bayer threshold, indexed by {y0, x0}.
    always_comb begin
      case ({y0, x0})
        2'b00:   t = 2'd0;
        2'b01:   t = 2'd2;
        2'b10:   t = 2'd3;
        default: t = 2'd1;
      endcase
    end

    // Scale the 2-bit threshold so that it spans the d bits being dropped.
    if (d >= 2) begin : g_ts_up
      assign ts = ws'(t) << (d - 2);
    end else begin : g_ts_dn
      assign ts = ws'(t >> (2 - d));
    end

    // The extra top bit catches the carry. A carry into bit w_out of the
    // quotient means overflow, so the output saturates instead of wrapping.
    assign sum        = {1'b0, din} + ts;
    assign q          = sum[w_in:d];
    assign unused_low = ^sum[d-1:0];
    assign dout       = q[w_out] ? {w_out{1'b1}} : q[w_out-1:0];
  end
endmodule

module vga_output_conditioner #(
  parameter int w_red_in        = 8,
  parameter int w_green_in      = 8,
  parameter int w_blue_in       = 8,
  parameter int w_red_out       = 2,
  parameter int w_green_out     = 2,
  parameter int w_blue_out      = 2,
  parameter int pipe_stages     = 1,
  parameter int sync_active_low = 0,
  parameter int dither_en       = 1,
  parameter int h_total         = 800,
  parameter int v_total         = 525
) (
  input logic                  clk,
  input logic                  rst,
  vga_output_conditioner_if.slave bus
);
  localparam logic sync_idle = (sync_active_low != 0);
  localparam int   hcnt_w    = $clog2(h_total + 1) + 1;
  localparam int   vcnt_w    = $clog2(v_total + 1) + 1;
  localparam logic [hcnt_w-1:0] h_total_c = hcnt_w'(h_total);
  localparam logic [vcnt_w-1:0] v_total_c = vcnt_w'(v_total);

  typedef enum logic {unarmed, armed} arm_e;

  // Colour conversion and blanking (input side)
  logic [w_red_out-1:0]   red_cv,   red_bl;
  logic [w_green_out-1:0] green_cv, green_bl;
  logic [w_blue_out-1:0]  blue_cv,  blue_bl;

  vga_chan_conv #(.w_in(w_red_in), .w_out(w_red_out), .dither_en(dither_en)) u_red (
    .din(bus.red_in), .x0(bus.x0), .y0(bus.y0), .dout(red_cv)
  );
  vga_chan_conv #(.w_in(w_green_in), .w_out(w_green_out), .dither_en(dither_en)) u_green (
    .din(bus.green_in), .x0(bus.x0), .y0(bus.y0), .dout(green_cv)
  );
  vga_chan_conv #(.w_in(w_blue_in), .w_out(w_blue_out), .dither_en(dither_en)) u_blue (
    .din(bus.blue_in), .x0(bus.x0), .y0(bus.y0), .dout(blue_cv)
  );

  // Blanking is applied after conversion, so dither can never leak into the
  // porches.
  assign red_bl   = bus.display_on ? red_cv   : '0;
  assign green_bl = bus.display_on ? green_cv : '0;
  assign blue_bl  = bus.display_on ? blue_cv  : '0;

  // Alignment pipeline. Polarity is applied before the first stage, so each
  // stage holds pin-level values. Reset therefore loads the idle level.
  logic                   hs_pipe    [pipe_stages];
  logic                   vs_pipe    [pipe_stages];
  logic [w_red_out-1:0]   red_pipe   [pipe_stages];
  logic [w_green_out-1:0] green_pipe [pipe_stages];
  logic [w_blue_out-1:0]  blue_pipe  [pipe_stages];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < pipe_stages; i++) begin
        hs_pipe[i]    <= sync_idle;
        vs_pipe[i]    <= sync_idle;
        red_pipe[i]   <= '0;
        green_pipe[i] <= '0;
        blue_pipe[i]  <= '0;
      end
    end else begin
      hs_pipe[0]    <= bus.hsync ^ sync_idle;
      vs_pipe[0]    <= bus.vsync ^ sync_idle;
      red_pipe[0]   <= red_bl;
      green_pipe[0] <= green_bl;
      blue_pipe[0]  <= blue_bl;
      for (int i = 1; i < pipe_stages; i++) begin
        hs_pipe[i]    <= hs_pipe[i-1];
        vs_pipe[i]    <= vs_pipe[i-1];
        red_pipe[i]   <= red_pipe[i-1];
        green_pipe[i] <= green_pipe[i-1];
        blue_pipe[i]  <= blue_pipe[i-1];
      end
    end
  end

  assign bus.vga_hsync = hs_pipe[pipe_stages-1];
  assign bus.vga_vsync = vs_pipe[pipe_stages-1];
  assign bus.vga_red   = red_pipe[pipe_stages-1];
  assign bus.vga_green = green_pipe[pipe_stages-1];
  assign bus.vga_blue  = blue_pipe[pipe_stages-1];

  // Timing checker (input side)
  logic              hs_prev, vs_prev;
  logic              hs_rise, vs_rise;
  logic [hcnt_w-1:0] hcnt;
  logic [vcnt_w-1:0] vcnt;
  arm_e              h_state, v_state;
  logic [2:0]        cause;

  assign hs_rise = bus.hsync & ~hs_prev;
  assign vs_rise = bus.vsync & ~vs_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      hcnt    <= '0;
      vcnt    <= '0;
      h_state <= unarmed;
      v_state <= unarmed;
      cause   <= '0;
    end else begin
      hs_prev <= bus.hsync;
      vs_prev <= bus.vsync;

      if (hs_rise) begin
        hcnt    <= hcnt_w'(1);
        h_state <= armed;
        if (h_state == armed && hcnt != h_total_c) cause[0] <= 1'b1;
      end else if (hcnt != {hcnt_w{1'b1}}) begin
        hcnt <= hcnt + 1'b1;
      end

      // When hsync and vsync rise together, that hsync edge is the first
      // line of the new frame.
      if (vs_rise) begin
        vcnt    <= hs_rise ? vcnt_w'(1) : '0;
        v_state <= armed;
        if (v_state == armed && vcnt != v_total_c) cause[1] <= 1'b1;
      end else if (hs_rise && vcnt != {vcnt_w{1'b1}}) begin
        vcnt <= vcnt + 1'b1;
      end

      if (bus.display_on & (bus.hsync | bus.vsync)) cause[2] <= 1'b1;
    end
  end

  assign bus.failure_cause  = cause;
  assign bus.sticky_failure = |cause;
endmodule
